// File: rtl/pads_pwr_seq.sv
// Pad-ring power sequencer: waits for a settled POC, then enables
// pad groups one at a time with a programmable stagger.
module pads_pwr_seq #(
  parameter int N_GROUPS   = 4,
  parameter int SETTLE_CYC = 16,
  parameter int STAGGER_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 poc_ok,
  input  logic                 pwr_req,
  input  logic [N_GROUPS-1:0]  grp_mask,
  input  logic [STAGGER_W-1:0] stagger_cfg,
  input  logic                 fault_clr,
  output logic [N_GROUPS-1:0]  grp_en,
  output logic                 seq_busy,
  output logic                 pwr_good,
  output logic                 poc_fault
);

  localparam int IW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
  localparam int CW = $clog2(SETTLE_CYC) + 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_RAMP_UP,
    S_ON,
    S_RAMP_DOWN
  } state_t;

  state_t               state, state_n;
  logic [N_GROUPS-1:0]  mask_l, mask_n;
  logic [STAGGER_W-1:0] cfg_l, cfg_n;
  logic [STAGGER_W-1:0] scnt, scnt_n;
  logic [CW-1:0]        setcnt, setcnt_n;
  logic [N_GROUPS-1:0]  grp_en_n;
  logic                 busy_n;
  logic                 good_n;
  logic                 fault_n;
  logic                 fault_set;

  logic [N_GROUPS-1:0]  pend;
  logic [IW-1:0]        lo_idx;
  logic                 lo_vld;
  logic [IW-1:0]        hi_idx;
  logic                 stag_hit;
  logic                 active;

  // Next group to enable (lowest pending) and to disable (highest on)
  always_comb begin
    pend   = mask_l & ~grp_en;
    lo_idx = '0;
    lo_vld = 1'b0;
    hi_idx = '0;
    for (int i = N_GROUPS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        lo_idx = IW'(i);
        lo_vld = 1'b1;
      end
    end
    for (int i = 0; i < N_GROUPS; i++) begin
      if (grp_en[i]) hi_idx = IW'(i);
    end
  end

  assign stag_hit = (scnt == cfg_l);
  assign active   = (state == S_RAMP_UP) || (state == S_ON) ||
                    (state == S_RAMP_DOWN);

  // Next-state and next-output logic; POC loss overrides everything
  always_comb begin
    state_n   = state;
    grp_en_n  = grp_en;
    mask_n    = mask_l;
    cfg_n     = cfg_l;
    scnt_n    = scnt;
    setcnt_n  = setcnt;
    fault_set = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pwr_req && poc_ok && !poc_fault) begin
          state_n  = S_SETTLE;
          mask_n   = grp_mask;
          cfg_n    = stagger_cfg;
          setcnt_n = '0;
        end
      end
      S_SETTLE: begin
        if (!pwr_req) begin
          state_n = S_IDLE;
        end else if (!poc_ok) begin
          setcnt_n = '0;
        end else if (setcnt == SETTLE_LAST) begin
          state_n = S_RAMP_UP;
          scnt_n  = cfg_l;
        end else begin
          setcnt_n = setcnt + 1'b1;
        end
      end
      S_RAMP_UP: begin
        if (!pwr_req) begin
          state_n = S_RAMP_DOWN;
          scnt_n  = cfg_l;
        end else if (!lo_vld) begin
          state_n = S_ON;
        end else if (stag_hit) begin
          grp_en_n[lo_idx] = 1'b1;
          scnt_n           = '0;
        end else begin
          scnt_n = scnt + 1'b1;
        end
      end
      S_ON: begin
        if (!pwr_req) begin
          state_n = S_RAMP_DOWN;
          scnt_n  = cfg_l;
        end
      end
      S_RAMP_DOWN: begin
        if (grp_en == '0) begin
          state_n = S_IDLE;
        end else if (stag_hit) begin
          grp_en_n[hi_idx] = 1'b0;
          scnt_n           = '0;
        end else begin
          scnt_n = scnt + 1'b1;
        end
      end
      default: begin
        state_n  = S_IDLE;
        grp_en_n = '0;
      end
    endcase
    if (active && !poc_ok) begin
      state_n   = S_IDLE;
      grp_en_n  = '0;
      scnt_n    = scnt;
      fault_set = |grp_en;
    end
  end

  assign busy_n  = (state_n == S_SETTLE) || (state_n == S_RAMP_UP) ||
                   (state_n == S_RAMP_DOWN);
  assign good_n  = (state_n == S_ON);
  assign fault_n = fault_set | (poc_fault & ~fault_clr);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      grp_en    <= '0;
      mask_l    <= '0;
      cfg_l     <= '0;
      scnt      <= '0;
      setcnt    <= '0;
      seq_busy  <= 1'b0;
      pwr_good  <= 1'b0;
      poc_fault <= 1'b0;
    end else begin
      state     <= state_n;
      grp_en    <= grp_en_n;
      mask_l    <= mask_n;
      cfg_l     <= cfg_n;
      scnt      <= scnt_n;
      setcnt    <= setcnt_n;
      seq_busy  <= busy_n;
      pwr_good  <= good_n;
      poc_fault <= fault_n;
    end
  end

endmodule
